bsg_rr_grant_sched: RTL and testbench

Registered round-robin grant scheduler that shares one downstream resource among `width_p` requesters. It sits in front of a shared datapath, such as a network output or a memory port. Each cycle it holds at most one one-hot grant plus its encoded index, and it advances a rotating priority pointer on every accepted grant. Selection is the lowest-index-first priority encode applied to a request vector rotated by the pointer, so service is starvation-free.

---
 rtl/bsg_rr_sched_pkg.sv | 17 +
 rtl/bsg_rr_grant_sched_if.sv | 39 +++
 rtl/bsg_rr_sched_penc.sv | 28 ++
 rtl/bsg_rr_sched_pick.sv | 51 +++++
 rtl/bsg_rr_grant_sched.sv | 117 +++++++++++
 tb/tb_bsg_rr_grant_sched.sv | 196 +++++++++++++++++++
 6 files changed

// File: rtl/bsg_rr_sched_pkg.sv
// Shared types for the round-robin grant scheduler: FSM state encoding and
// the pointer reset value that gives index 0 first priority after reset.
package bsg_rr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    LOCK  = 2'd2
  } sched_state_e;

  // The pointer names the last served index, so resetting it to the top
  // index makes index 0 the first one considered.
  function automatic int rr_reset_ptr(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/bsg_rr_grant_sched_if.sv
// Handshake bundle between requesters/consumer and the round-robin scheduler.
// last_i is present only when BSG_RR_SCHED_LOCK_EN is defined.
interface bsg_rr_grant_sched_if #(
  parameter  int width_p    = 32,
  localparam int lg_width_p = $clog2(width_p)
);

  logic [width_p-1:0]    reqs_i;
  logic                  yumi_i;
`ifdef BSG_RR_SCHED_LOCK_EN
  logic                  last_i;
`endif
  logic [width_p-1:0]    grants_o;
  logic [lg_width_p-1:0] addr_o;
  logic                  v_o;

  modport master (
    output reqs_i,
    output yumi_i,
`ifdef BSG_RR_SCHED_LOCK_EN
    output last_i,
`endif
    input  grants_o,
    input  addr_o,
    input  v_o
  );

  modport slave (
    input  reqs_i,
    input  yumi_i,
`ifdef BSG_RR_SCHED_LOCK_EN
    input  last_i,
`endif
    output grants_o,
    output addr_o,
    output v_o
  );

endinterface

// File: rtl/bsg_rr_sched_penc.sv
// Lowest-index-first priority encoder: one-hot of the lowest set bit, its
// binary index, and a valid flag when any bit is set.
module bsg_rr_sched_penc #(
  parameter  int width_p    = 32,
  localparam int lg_width_p = $clog2(width_p)
) (
  input  logic [width_p-1:0]    bits_i,
  output logic [width_p-1:0]    one_hot_o,
  output logic [lg_width_p-1:0] idx_o,
  output logic                  v_o
);

  // Scanning from the top down lets the lowest set bit win the last write.
  always_comb begin
    one_hot_o = '0;
    idx_o     = '0;
    v_o       = 1'b0;
    for (int i = width_p - 1; i >= 0; i--) begin
      if (bits_i[i]) begin
        one_hot_o    = '0;
        one_hot_o[i] = 1'b1;
        idx_o        = i[lg_width_p-1:0];
        v_o          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_rr_sched_pick.sv
// Combinational round-robin pick: requests above the pointer win first,
// otherwise wrap around to the lowest requester overall.
module bsg_rr_sched_pick #(
  parameter  int width_p    = 32,
  localparam int lg_width_p = $clog2(width_p)
) (
  input  logic [width_p-1:0]    reqs_i,
  input  logic [lg_width_p-1:0] ptr_i,
  output logic [width_p-1:0]    grant_o,
  output logic [lg_width_p-1:0] addr_o,
  output logic                  v_o
);

  logic [width_p-1:0]    mask;
  logic [width_p-1:0]    masked_reqs;
  logic [width_p-1:0]    m_grant;
  logic [width_p-1:0]    u_grant;
  logic [lg_width_p-1:0] m_addr;
  logic [lg_width_p-1:0] u_addr;
  logic                  m_v;
  logic                  u_v;

  // Bits 0..ptr are cleared so the pointer's own index ends up lowest priority.
  always_comb begin
    mask = '0;
    for (int i = 0; i < width_p; i++) begin
      mask[i] = (i > 32'(ptr_i));
    end
  end

  assign masked_reqs = reqs_i & mask;

  bsg_rr_sched_penc #(.width_p(width_p)) masked_enc (
    .bits_i    (masked_reqs),
    .one_hot_o (m_grant),
    .idx_o     (m_addr),
    .v_o       (m_v)
  );

  bsg_rr_sched_penc #(.width_p(width_p)) unmasked_enc (
    .bits_i    (reqs_i),
    .one_hot_o (u_grant),
    .idx_o     (u_addr),
    .v_o       (u_v)
  );

  assign grant_o = m_v ? m_grant : u_grant;
  assign addr_o  = m_v ? m_addr  : u_addr;
  assign v_o     = u_v;

endmodule

// File: rtl/bsg_rr_grant_sched.sv
// Registered round-robin grant scheduler; define BSG_RR_SCHED_LOCK_EN to hold
// a grant across multi-beat transfers until last_i accompanies yumi_i.
module bsg_rr_grant_sched
  import bsg_rr_sched_pkg::*;
#(
  parameter  int width_p    = 32,
  localparam int lg_width_p = $clog2(width_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  bsg_rr_grant_sched_if.slave  sched_if
);

  localparam logic [lg_width_p-1:0] ptr_reset_lp = lg_width_p'(rr_reset_ptr(width_p));

  sched_state_e          state_r, state_n;
  logic [lg_width_p-1:0] ptr_r, ptr_n;
  logic [lg_width_p-1:0] addr_r, addr_n;
  logic [width_p-1:0]    grants_r, grants_n;
  logic                  v_r, v_n;
  logic [lg_width_p-1:0] pick_ptr;
  logic [width_p-1:0]    pick_grant;
  logic [lg_width_p-1:0] pick_addr;
  logic                  pick_v;
  logic                  accept;

  // An accepted grant re-arbitrates in the same cycle against the index just
  // served, so the pick sees the pointer value it is about to load.
`ifdef BSG_RR_SCHED_LOCK_EN
  assign accept = sched_if.yumi_i && sched_if.last_i
                  && ((state_r == GRANT) || (state_r == LOCK));
`else
  assign accept = sched_if.yumi_i && (state_r == GRANT);
`endif
  assign pick_ptr = accept ? addr_r : ptr_r;

  bsg_rr_sched_pick #(.width_p(width_p)) pick (
    .reqs_i  (sched_if.reqs_i),
    .ptr_i   (pick_ptr),
    .grant_o (pick_grant),
    .addr_o  (pick_addr),
    .v_o     (pick_v)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= IDLE;
      ptr_r    <= ptr_reset_lp;
      addr_r   <= '0;
      grants_r <= '0;
      v_r      <= 1'b0;
    end else begin
      state_r  <= state_n;
      ptr_r    <= ptr_n;
      addr_r   <= addr_n;
      grants_r <= grants_n;
      v_r      <= v_n;
    end
  end

  always_comb begin
    state_n  = state_r;
    ptr_n    = ptr_r;
    addr_n   = addr_r;
    grants_n = grants_r;
    v_n      = v_r;

    case (state_r)
      IDLE: begin
        if (pick_v) begin
          grants_n = pick_grant;
          addr_n   = pick_addr;
          v_n      = 1'b1;
          state_n  = GRANT;
        end
      end
      GRANT: begin
`ifdef BSG_RR_SCHED_LOCK_EN
        if (sched_if.yumi_i && !sched_if.last_i) begin
          state_n = LOCK;
        end
`endif
      end
`ifdef BSG_RR_SCHED_LOCK_EN
      LOCK: begin
        state_n = LOCK;
      end
`endif
      default: begin
        state_n  = IDLE;
        grants_n = '0;
        addr_n   = '0;
        v_n      = 1'b0;
      end
    endcase

    if (accept) begin
      ptr_n = addr_r;
      if (pick_v) begin
        grants_n = pick_grant;
        addr_n   = pick_addr;
        v_n      = 1'b1;
        state_n  = GRANT;
      end else begin
        grants_n = '0;
        addr_n   = '0;
        v_n      = 1'b0;
        state_n  = IDLE;
      end
    end
  end

  assign sched_if.grants_o = grants_r;
  assign sched_if.addr_o   = addr_r;
  assign sched_if.v_o      = v_r;

endmodule

// File: tb/tb_bsg_rr_grant_sched.sv
// Scoreboard bench for bsg_rr_grant_sched at width 4: a rotation-search model
// predicts every cycle's outputs; directed cases pin the documented scenarios.
module tb_bsg_rr_grant_sched;

  localparam int W = 4;
`ifdef BSG_RR_SCHED_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] g;
    logic [1:0]   a;
    logic         v;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   held        = -1;
  int   last_served = W - 1;
  exp_t exp_q[$];
  exp_t mon_e;
  exp_t mdl_e;

  bsg_rr_grant_sched_if #(.width_p(W)) sif ();

  bsg_rr_grant_sched #(.width_p(W)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .sched_if  (sif)
  );

  always #5 clk = ~clk;

  // Next requester strictly after 'from' going around the ring.
  function automatic int nextReq(input logic [W-1:0] r, input int from);
    for (int k = 1; k <= W; k++) begin
      if (r[(from + k) % W]) return (from + k) % W;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] g,
                             input logic [1:0] a, input logic v);
    total_cnt++;
    if (sif.grants_o === g && sif.addr_o === a && sif.v_o === v) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s at %0t: got grants=%b addr=%0d v=%b, expected grants=%b addr=%0d v=%b",
               name, $time, sif.grants_o, sif.addr_o, sif.v_o, g, a, v);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] r, input logic y, input logic l);
    sif.reqs_i = r;
    sif.yumi_i = y;
`ifdef BSG_RR_SCHED_LOCK_EN
    sif.last_i = l;
`else
    if (l) begin end
`endif
  endtask

  task automatic stepCheck(input string name, input logic [W-1:0] r, input logic y,
                           input logic l, input logic [W-1:0] g, input logic [1:0] a,
                           input logic v);
    @(negedge clk);
    applyStimulus(r, y, l);
    @(posedge clk);
    #2;
    checkOutput(name, g, a, v);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    applyStimulus('0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Reference model: one served-index memory and the currently held grant.
  always @(posedge clk) begin
    logic lastv;
`ifdef BSG_RR_SCHED_LOCK_EN
    lastv = sif.last_i;
`else
    lastv = 1'b1;
`endif
    if (!reset_n) begin
      held        = -1;
      last_served = W - 1;
    end else if (held < 0) begin
      if (sif.reqs_i != '0) held = nextReq(sif.reqs_i, last_served);
    end else if (sif.yumi_i && (lastv || !LOCK_EN)) begin
      last_served = held;
      held        = nextReq(sif.reqs_i, last_served);
    end
    mdl_e.v = (held >= 0);
    mdl_e.g = (held >= 0) ? W'(1 << held) : '0;
    mdl_e.a = (held >= 0) ? 2'(held) : 2'd0;
    exp_q.push_back(mdl_e);
  end

  always @(posedge clk) begin
    #1;
    if (exp_q.size() == 0) begin
      total_cnt++;
      $display("[TB] FAIL sb_underflow at %0t: got no expected entry, required one", $time);
    end else begin
      mon_e = exp_q.pop_front();
      checkOutput("sb_cycle", mon_e.g, mon_e.a, mon_e.v);
    end
  end

  initial begin
    logic [W-1:0] r;
    logic         y;
    logic         l;
    applyStimulus('0, 1'b0, 1'b1);

    // Reset release with a pending request pattern.
    @(negedge clk);
    applyStimulus(4'b1010, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("reset_state", 4'b0000, 2'd0, 1'b0);
    reset_n = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("first_grant", 4'b0010, 2'd1, 1'b1);

    // Full requests with continuous acceptance.
    doReset();
    stepCheck("rr_0", 4'b1111, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1);
    stepCheck("rr_1", 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1);
    stepCheck("rr_2", 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1);
    stepCheck("rr_3", 4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1);
    stepCheck("rr_wrap", 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1);

    // Stalled grant stays put while other requests churn.
    doReset();
    stepCheck("stall_start", 4'b1001, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      r = W'($urandom) | 4'b0001;
      stepCheck("stall_hold", r, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1);
    end

    // Lone requester accepted and dropped, then pointer shows up as priority.
    doReset();
    stepCheck("single_grant", 4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1);
    stepCheck("single_idle", 4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0);
    stepCheck("ptr_after_2", 4'b1111, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b1);

    // Asynchronous reset while a grant is held.
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset", 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b1111, 1'b0, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("restart_idx0", 4'b0001, 2'd0, 1'b1);

`ifdef BSG_RR_SCHED_LOCK_EN
    doReset();
    stepCheck("lock_grant", 4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1);
    stepCheck("lock_beat1", 4'b1111, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1);
    stepCheck("lock_beat2", 4'b1111, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1);
    stepCheck("lock_last",  4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1);
`endif

    // Randomized traffic; the granted requester keeps its bit until accepted.
    doReset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      r = W'($urandom);
      if ($urandom_range(0, 4) == 0) r = '0;
      y = (held >= 0) && ($urandom_range(0, 1) == 1);
      l = ($urandom_range(0, 2) != 0);
      if (held >= 0 && !(y && (l || !LOCK_EN))) r[held] = 1'b1;
      applyStimulus(r, y, l);
    end

    @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
